pru_sync_core: RTL and testbench

Synchronous DAG processing unit: a small programmable datapath that evaluates arithmetic DAGs (sum/product nodes) stored as an instruction list over a local data memory. A host loads the data memory and instruction memory through init ports, pulses execution on, and tracks progress through the exported instruction read address. It sits below the top-level accelerator wrapper as the single compute element.

---
 rtl/pru_sync_pkg.sv | 38 +++
 rtl/pru_sync_mem.sv | 34 +++
 rtl/pru_sync_core.sv | 207 ++++++++++++++++++++
 tb/tb_pru_sync_core.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pru_sync_pkg.sv
// Shared types for the PRU sync core: opcodes, FSM states, instruction layout,
// default widths, and a small helper for the datapath.
package pru_sync_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DADDR_W = 8;
    localparam int DEF_IADDR_W = 8;
    localparam int DEF_INSTR_W = 4 + 3 * DEF_DADDR_W;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_MUL  = 4'd2,
        OP_HALT = 4'd3
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_OPRD,
        ST_EXEC,
        ST_HALTED
    } state_e;

    // Instruction layout at the default address width, MSB first.
    typedef struct packed {
        logic [3:0]             opcode;
        logic [DEF_DADDR_W-1:0] dst;
        logic [DEF_DADDR_W-1:0] src0;
        logic [DEF_DADDR_W-1:0] src1;
    } instr_t;

    // Only ADD and MUL write the data memory; every other opcode is a no-op.
    function automatic logic is_write_op(input opcode_e op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/pru_sync_mem.sv
// Data memory for the PRU sync core: one synchronous write port and two
// synchronous read ports with read enables. Reads are write-first, so a read
// of the address being written in the same cycle returns the new value.
// Contents are never cleared.
module pru_sync_mem #(
    parameter int W  = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re0,
    input  logic [AW-1:0] raddr0,
    output logic [W-1:0]  rdata0,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [W-1:0]  rdata1
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    // Single write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Two registered read ports; each holds its last value when not enabled.
    always_ff @(posedge clk) begin
        if (re0) rdata0 <= (we && (waddr == raddr0)) ? wdata : mem[raddr0];
        if (re1) rdata1 <= (we && (waddr == raddr1)) ? wdata : mem[raddr1];
    end

endmodule

// File: rtl/pru_sync_core.sv
// PRU sync core: evaluates sum/product DAGs stored as an instruction list over
// a local data memory, three cycles per instruction.
// Optional INSTR_PING_PONG_EN: two instruction banks, host writes bank
// io_ping_wr while execution fetches the other; toggling io_ping_wr restarts
// the program at PC 0 on the new bank.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | stopped, PC held; host data/instruction ports active
// ST_FETCH  | read instruction memory at PC
// ST_OPRD   | read mem[src0] and mem[src1]
// ST_EXEC   | write mem[dst] for ADD/MUL, advance PC or stop on HALT
// ST_HALTED | HALT reached, PC holds HALT address; host ports active
module pru_sync_core
    import pru_sync_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DADDR_W = DEF_DADDR_W,
    parameter int IADDR_W = DEF_IADDR_W,
    parameter int INSTR_W = 4 + 3 * DADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_execution,
    input  logic [INSTR_W-1:0] init_instr,
    input  logic [IADDR_W-1:0] init_instr_addr,
    input  logic               init_instr_we,
`ifdef INSTR_PING_PONG_EN
    input  logic               io_ping_wr,
`endif
    output logic [IADDR_W-1:0] current_instr_rd_addr,
    input  logic [DATA_W-1:0]  init_data_in,
    output logic [DATA_W-1:0]  init_data_out,
    input  logic [DADDR_W-1:0] init_data_addr,
    input  logic               init_data_we,
    input  logic               init_data_re
);

    state_e             state;
    logic [IADDR_W-1:0] pc;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] fetch_word;
    logic               host_ok;
    logic               toggle;

    opcode_e            opc;
    logic [DADDR_W-1:0] dst;
    logic [DADDR_W-1:0] src0;
    logic [DADDR_W-1:0] src1;

    logic               mem_we;
    logic [DADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               mem_re0;
    logic [DADDR_W-1:0] mem_raddr0;
    logic [DATA_W-1:0]  rdata0;
    logic [DATA_W-1:0]  rdata1;
    logic [DATA_W-1:0]  alu_res;

    logic               host_rd_q;
    logic [DATA_W-1:0]  host_held;

    assign opc  = opcode_e'(instr_q[INSTR_W-1 -: 4]);
    assign dst  = instr_q[3*DADDR_W-1 -: DADDR_W];
    assign src0 = instr_q[2*DADDR_W-1 -: DADDR_W];
    assign src1 = instr_q[DADDR_W-1:0];

    assign host_ok               = (state == ST_IDLE) || (state == ST_HALTED);
    assign current_instr_rd_addr = pc;

`ifdef INSTR_PING_PONG_EN
    logic [INSTR_W-1:0] imem0 [0:(1<<IADDR_W)-1];
    logic [INSTR_W-1:0] imem1 [0:(1<<IADDR_W)-1];
    logic               ping_q;

    // Host writes go to the bank selected by io_ping_wr, in any state.
    always_ff @(posedge clk) begin
        if (init_instr_we) begin
            if (io_ping_wr) imem1[init_instr_addr] <= init_instr;
            else            imem0[init_instr_addr] <= init_instr;
        end
    end

    // Registered copy of the bank select for toggle detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ping_q <= 1'b0;
        else     ping_q <= io_ping_wr;
    end

    assign toggle     = ping_q ^ io_ping_wr;
    assign fetch_word = io_ping_wr ? imem0[pc] : imem1[pc];
`else
    logic [INSTR_W-1:0] imem [0:(1<<IADDR_W)-1];

    // Host instruction writes only while the core is stopped.
    always_ff @(posedge clk) begin
        if (init_instr_we && host_ok) imem[init_instr_addr] <= init_instr;
    end

    assign toggle     = 1'b0;
    assign fetch_word = imem[pc];
`endif

    // Arithmetic on the operands captured during OPRD; wraps modulo 2^DATA_W.
    always_comb begin
        alu_res = '0;
        case (opc)
            OP_ADD:  alu_res = rdata0 + rdata1;
            OP_MUL:  alu_res = rdata0 * rdata1;
            default: alu_res = '0;
        endcase
    end

    // Data memory port steering: execution owns the ports while running,
    // the host owns them in IDLE/HALTED.
    always_comb begin
        mem_we     = 1'b0;
        mem_waddr  = init_data_addr;
        mem_wdata  = init_data_in;
        mem_re0    = 1'b0;
        mem_raddr0 = init_data_addr;
        if (state == ST_EXEC && !toggle && is_write_op(opc)) begin
            mem_we    = 1'b1;
            mem_waddr = dst;
            mem_wdata = alu_res;
        end else if (host_ok && init_data_we) begin
            mem_we = 1'b1;
        end
        if (state == ST_OPRD) begin
            mem_re0    = 1'b1;
            mem_raddr0 = src0;
        end else if (host_ok && init_data_re) begin
            mem_re0 = 1'b1;
        end
    end

    pru_sync_mem #(
        .W  (DATA_W),
        .AW (DADDR_W)
    ) u_dmem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .re0    (mem_re0),
        .raddr0 (mem_raddr0),
        .rdata0 (rdata0),
        .re1    (state == ST_OPRD),
        .raddr1 (src1),
        .rdata1 (rdata1)
    );

    // Read port 0 is shared with operand fetch, so the last host read result
    // is parked in host_held before OPRD overwrites the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rd_q <= 1'b0;
            host_held <= '0;
        end else begin
            if (host_rd_q) host_held <= rdata0;
            if (mem_re0)   host_rd_q <= host_ok && init_data_re;
        end
    end

    assign init_data_out = host_rd_q ? rdata0 : host_held;

    // Sequencer: FETCH/OPRD/EXEC per instruction; a bank toggle overrides all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc      <= '0;
            instr_q <= '0;
        end else if (toggle) begin
            pc    <= '0;
            state <= enable_execution ? ST_FETCH : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable_execution) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    instr_q <= fetch_word;
                    state   <= ST_OPRD;
                end
                ST_OPRD: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (opc == OP_HALT) begin
                        state <= ST_HALTED;
                    end else begin
                        pc    <= pc + IADDR_W'(1);
                        state <= enable_execution ? ST_FETCH : ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    if (!enable_execution) begin
                        state <= ST_IDLE;
                        pc    <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pru_sync_core.sv
// Bench for pru_sync_core: directed programs from the feature list plus
// random programs checked against an instruction-level reference model.
// Builds with or without INSTR_PING_PONG_EN.
module tb_pru_sync_core;

    localparam int DW  = 32;
    localparam int DAW = 8;
    localparam int IAW = 8;
    localparam int IW  = 4 + 3 * DAW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable_execution = 1'b0;
    logic [IW-1:0]  init_instr = '0;
    logic [IAW-1:0] init_instr_addr = '0;
    logic           init_instr_we = 1'b0;
`ifdef INSTR_PING_PONG_EN
    logic           io_ping_wr = 1'b0;
`endif
    logic [IAW-1:0] current_instr_rd_addr;
    logic [DW-1:0]  init_data_in = '0;
    logic [DW-1:0]  init_data_out;
    logic [DAW-1:0] init_data_addr = '0;
    logic           init_data_we = 1'b0;
    logic           init_data_re = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    logic [DW-1:0] ref_mem [0:15];
    logic [IW-1:0] prog    [0:15];

    pru_sync_core dut (
        .clk                   (clk),
        .rst                   (rst),
        .enable_execution      (enable_execution),
        .init_instr            (init_instr),
        .init_instr_addr       (init_instr_addr),
        .init_instr_we         (init_instr_we),
`ifdef INSTR_PING_PONG_EN
        .io_ping_wr            (io_ping_wr),
`endif
        .current_instr_rd_addr (current_instr_rd_addr),
        .init_data_in          (init_data_in),
        .init_data_out         (init_data_out),
        .init_data_addr        (init_data_addr),
        .init_data_we          (init_data_we),
        .init_data_re          (init_data_re)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input int d, input int a, input int b);
        return {op, 8'(d), 8'(a), 8'(b)};
    endfunction

    task automatic host_write(input int a, input logic [DW-1:0] v);
        init_data_addr = 8'(a);
        init_data_in   = v;
        init_data_we   = 1'b1;
        tick();
        init_data_we   = 1'b0;
    endtask

    task automatic set_data(input int a, input logic [DW-1:0] v);
        host_write(a, v);
        ref_mem[a] = v;
    endtask

    task automatic host_read(input int a, output logic [DW-1:0] d);
        init_data_addr = 8'(a);
        init_data_re   = 1'b1;
        tick();
        init_data_re   = 1'b0;
        d = init_data_out;
    endtask

    task automatic load_prog(input int n);
`ifdef INSTR_PING_PONG_EN
        io_ping_wr = 1'b1;
        tick();
`endif
        for (int i = 0; i < n; i++) begin
            init_instr_addr = 8'(i);
            init_instr      = prog[i];
            init_instr_we   = 1'b1;
            tick();
        end
        init_instr_we = 1'b0;
`ifdef INSTR_PING_PONG_EN
        io_ping_wr = 1'b0;
        tick();
`endif
    endtask

    // Instruction-level model: executes prog[] from 0 until HALT.
    task automatic model_run(input int n);
        logic [3:0] op;
        int d, a, b;
        for (int i = 0; i < n; i++) begin
            op = prog[i][27:24];
            d  = int'(prog[i][23:16]);
            a  = int'(prog[i][15:8]);
            b  = int'(prog[i][7:0]);
            if (op == 4'd3) break;
            if (op == 4'd1) ref_mem[d] = ref_mem[a] + ref_mem[b];
            else if (op == 4'd2) ref_mem[d] = ref_mem[a] * ref_mem[b];
        end
    endtask

    // Runs an n-instruction program (last one HALT) from PC 0, checking the
    // PC every cycle against the 3-cycles-per-instruction timing, and pokes
    // the host port mid-run, which must be ignored.
    task automatic run_prog(input int n);
        logic [DW-1:0] d, held;
        int exp_pc;
        host_read(0, d);
        check_val("pre_rd", d, ref_mem[0]);
        held = ref_mem[0];
        enable_execution = 1'b1;
        for (int t = 1; t <= 3 * n + 1; t++) begin
            if (t == 2) begin
                init_data_addr = 8'($urandom_range(0, 15));
                init_data_in   = $urandom;
                init_data_we   = 1'b1;
                init_data_re   = 1'b1;
            end
            tick();
            init_data_we = 1'b0;
            init_data_re = 1'b0;
            exp_pc = (t - 1) / 3;
            if (exp_pc > n - 1) exp_pc = n - 1;
            check_val("pc_run", 32'(current_instr_rd_addr), 32'(exp_pc));
        end
        check_val("out_held_run", init_data_out, held);
        enable_execution = 1'b0;
        tick();
        check_val("pc_after_halt", 32'(current_instr_rd_addr), 32'd0);
        model_run(n);
    endtask

    initial begin
        logic [DW-1:0] d;
        int L;
        logic [3:0] op;

        // Reset
        tick(); tick();
        check_val("rst_pc", 32'(current_instr_rd_addr), 32'd0);
        check_val("rst_out", init_data_out, 32'd0);
        rst = 1'b0;
        tick();
        check_val("rst_pc_post", 32'(current_instr_rd_addr), 32'd0);
        check_val("rst_out_post", init_data_out, 32'd0);

        for (int a = 0; a < 16; a++) set_data(a, 32'h0);

        // Basic DAG: (3+5)^2
        set_data(1, 32'd3);
        set_data(2, 32'd5);
        prog[0] = mk(4'd1, 3, 1, 2);
        prog[1] = mk(4'd2, 4, 3, 3);
        prog[2] = mk(4'd3, 0, 0, 0);
        load_prog(3);
        run_prog(3);
        host_read(4, d); check_val("dag_mem4", d, 32'd64);
        host_read(3, d); check_val("dag_mem3", d, 32'd8);

        // Wraparound arithmetic
        set_data(1, 32'hFFFF_FFFF);
        set_data(2, 32'd2);
        set_data(5, 32'd1);
        prog[0] = mk(4'd2, 3, 1, 2);
        prog[1] = mk(4'd1, 4, 1, 5);
        prog[2] = mk(4'd3, 0, 0, 0);
        load_prog(3);
        run_prog(3);
        host_read(3, d); check_val("mul_wrap", d, 32'hFFFF_FFFE);
        host_read(4, d); check_val("add_wrap", d, 32'h0);

        // Enable dropped during OPRD of instruction 1
        set_data(1, 32'd3);
        set_data(2, 32'd5);
        set_data(3, 32'd0);
        set_data(4, 32'd0);
        prog[0] = mk(4'd1, 3, 1, 2);
        prog[1] = mk(4'd2, 4, 3, 3);
        prog[2] = mk(4'd3, 0, 0, 0);
        load_prog(3);
        enable_execution = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        enable_execution = 1'b0;
        tick(); tick();
        check_val("drop_pc", 32'(current_instr_rd_addr), 32'd2);
        tick(); tick(); tick();
        check_val("drop_pc_hold", 32'(current_instr_rd_addr), 32'd2);
        host_read(4, d); check_val("drop_mem4", d, 32'd64);
        host_read(3, d); check_val("drop_mem3", d, 32'd8);
        enable_execution = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_val("resume_halt_pc", 32'(current_instr_rd_addr), 32'd2);
        enable_execution = 1'b0;
        tick();
        check_val("resume_idle_pc", 32'(current_instr_rd_addr), 32'd0);
        model_run(3);

        // Host port behaviour in IDLE
        set_data(7, 32'hA5A5_5A5A);
        host_read(7, d); check_val("idle_rd", d, 32'hA5A5_5A5A);
        tick(); tick();
        check_val("out_hold", init_data_out, 32'hA5A5_5A5A);
        init_data_addr = 8'd2;
        init_data_re   = 1'b1;
        #1;
        check_val("rd_before_edge", init_data_out, 32'hA5A5_5A5A);
        tick();
        init_data_re = 1'b0;
        check_val("rd_after_edge", init_data_out, ref_mem[2]);
        init_data_addr = 8'd7;
        init_data_in   = 32'h1234_5678;
        init_data_we   = 1'b1;
        init_data_re   = 1'b1;
        tick();
        init_data_we = 1'b0;
        init_data_re = 1'b0;
        ref_mem[7]   = 32'h1234_5678;
        check_val("wr_rd_same", init_data_out, 32'h1234_5678);

        // Random programs against the model
        for (int it = 0; it < 10; it++) begin
            for (int a = 0; a < 16; a++)
                set_data(a, (it % 2 == 0) ? 32'($urandom_range(0, 1000)) : $urandom);
            L = $urandom_range(1, 10);
            for (int i = 0; i < L; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'd3) op = 4'd1;
                prog[i] = mk(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            end
            prog[L] = mk(4'd3, 0, 0, 0);
            load_prog(L + 1);
            run_prog(L + 1);
            for (int a = 0; a < 16; a++) begin
                host_read(a, d);
                check_val("rand_mem", d, ref_mem[a]);
            end
        end

`ifdef INSTR_PING_PONG_EN
        // Run bank 1 while writing bank 0, then switch banks mid-program
        set_data(1, 32'd3);
        set_data(2, 32'd5);
        set_data(3, 32'd0);
        set_data(4, 32'd0);
        set_data(6, 32'd0);
        prog[0] = mk(4'd1, 3, 1, 2);
        prog[1] = mk(4'd2, 4, 3, 3);
        prog[2] = mk(4'd3, 0, 0, 0);
        load_prog(3);
        enable_execution = 1'b1;
        tick(); tick();
        init_instr_we   = 1'b1;
        init_instr_addr = 8'd0;
        init_instr      = mk(4'd1, 6, 1, 1);
        tick();
        init_instr_addr = 8'd1;
        init_instr      = mk(4'd3, 0, 0, 0);
        tick();
        init_instr_we = 1'b0;
        check_val("pp_pc_before", 32'(current_instr_rd_addr), 32'd1);
        io_ping_wr = 1'b1;
        tick();
        check_val("pp_pc_reset", 32'(current_instr_rd_addr), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check_val("pp_halt_pc", 32'(current_instr_rd_addr), 32'd1);
        enable_execution = 1'b0;
        tick();
        check_val("pp_idle_pc", 32'(current_instr_rd_addr), 32'd0);
        host_read(6, d); check_val("pp_bank_result", d, 32'd6);
        host_read(3, d); check_val("pp_first_instr", d, 32'd8);
        host_read(4, d); check_val("pp_aborted", d, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
